// File: rtl/ddr_ring_addr_gen.sv
// rtl/ddr_ring_addr_gen.sv - DDR ring-of-blocks burst address generator with block-level read/write gating
// Optional fill-level outputs (fill_words, almost_full) exist only when DDR_ADDR_LEVEL_EN is defined.
module ddr_ring_addr_gen #(
   parameter int ADDR_WIDTH  = 25,
   parameter int BURST_LEN   = 2,
   parameter int BLOCK_WORDS = 1024,
   parameter int NUM_BLOCKS  = 4,
   parameter int BASE_ADDR   = 0,
   parameter int ALMOST_FULL = 3072
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_addr_up,
   input  logic                            rd_addr_up,
   input  logic                            clr_err,
   output logic [ADDR_WIDTH-1:0]           wr_addr,
   output logic [ADDR_WIDTH-1:0]           rd_addr,
   output logic                            write_en,
   output logic                            read_en,
   output logic [$clog2(NUM_BLOCKS+1)-1:0] filled_blks,
   output logic                            overflow,
   output logic                            underflow
`ifdef DDR_ADDR_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]             fill_words,
   output logic                            almost_full
`endif
);

   localparam int OFF_W = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;
   localparam int BLK_W = $clog2(NUM_BLOCKS);
   localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

   localparam logic [OFF_W-1:0]      OFF_LAST  = OFF_W'(BLOCK_WORDS - BURST_LEN);
   localparam logic [OFF_W-1:0]      OFF_STEP  = OFF_W'(BURST_LEN);
   localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(NUM_BLOCKS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN);

   logic [OFF_W-1:0] wr_off, rd_off;
   logic [BLK_W-1:0] wr_blk, rd_blk;
   logic             wr_acc, rd_acc, wr_done, rd_done;
   logic [CNT_W-1:0] filled_next;

   assign wr_acc  = wr_addr_up & write_en;
   assign rd_acc  = rd_addr_up & read_en;
   assign wr_done = wr_acc & (wr_off == OFF_LAST);
   assign rd_done = rd_acc & (rd_off == OFF_LAST);

   // A block completing and another being consumed in the same cycle cancel out.
   always_comb begin
      filled_next = filled_blks;
      if (wr_done && !rd_done)
         filled_next = filled_blks + CNT_W'(1);
      else if (rd_done && !wr_done)
         filled_next = filled_blks - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr     <= ADDR_BASE;
         rd_addr     <= ADDR_BASE;
         wr_off      <= '0;
         rd_off      <= '0;
         wr_blk      <= '0;
         rd_blk      <= '0;
         filled_blks <= '0;
         write_en    <= 1'b1;
         read_en     <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (wr_acc) begin
            if (wr_off == OFF_LAST) begin
               wr_off <= '0;
               if (wr_blk == BLK_LAST) begin
                  wr_blk  <= '0;
                  wr_addr <= ADDR_BASE;
               end else begin
                  wr_blk  <= wr_blk + BLK_W'(1);
                  wr_addr <= wr_addr + ADDR_STEP;
               end
            end else begin
               wr_off  <= wr_off + OFF_STEP;
               wr_addr <= wr_addr + ADDR_STEP;
            end
         end
         if (rd_acc) begin
            if (rd_off == OFF_LAST) begin
               rd_off <= '0;
               if (rd_blk == BLK_LAST) begin
                  rd_blk  <= '0;
                  rd_addr <= ADDR_BASE;
               end else begin
                  rd_blk  <= rd_blk + BLK_W'(1);
                  rd_addr <= rd_addr + ADDR_STEP;
               end
            end else begin
               rd_off  <= rd_off + OFF_STEP;
               rd_addr <= rd_addr + ADDR_STEP;
            end
         end
         filled_blks <= filled_next;
         write_en    <= (filled_next != CNT_FULL);
         read_en     <= (filled_next != '0);
         // A new error wins over clr_err in the same cycle.
         overflow    <= (overflow  & ~clr_err) | (wr_addr_up & ~write_en);
         underflow   <= (underflow & ~clr_err) | (rd_addr_up & ~read_en);
      end
   end

`ifdef DDR_ADDR_LEVEL_EN
   localparam logic [ADDR_WIDTH:0] FW_STEP = (ADDR_WIDTH+1)'(BURST_LEN);
   localparam logic [ADDR_WIDTH:0] FW_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL);

   logic [ADDR_WIDTH:0] fill_next;

   always_comb begin
      fill_next = fill_words;
      if (wr_acc && !rd_acc)
         fill_next = fill_words + FW_STEP;
      else if (rd_acc && !wr_acc)
         fill_next = fill_words - FW_STEP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_words  <= '0;
         almost_full <= 1'b0;
      end else begin
         fill_words  <= fill_next;
         almost_full <= (fill_next >= FW_AF);
      end
   end
`endif

endmodule

// File: tb/tb_ddr_ring_addr_gen.sv
// tb/tb_ddr_ring_addr_gen.sv - scoreboard bench for ddr_ring_addr_gen (BURST_LEN=2, BLOCK_WORDS=8, NUM_BLOCKS=2, BASE_ADDR=0x100)
module tb_ddr_ring_addr_gen;

   localparam int AW = 25;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_addr_up = 1'b0;
   logic          rd_addr_up = 1'b0;
   logic          clr_err = 1'b0;
   logic [AW-1:0] wr_addr, rd_addr;
   logic          write_en, read_en;
   logic [1:0]    filled_blks;
   logic          overflow, underflow;
`ifdef DDR_ADDR_LEVEL_EN
   logic [AW:0]   fill_words;
   logic          almost_full;
`endif

   ddr_ring_addr_gen #(
      .ADDR_WIDTH(AW), .BURST_LEN(2), .BLOCK_WORDS(8),
      .NUM_BLOCKS(2), .BASE_ADDR(32'h100), .ALMOST_FULL(12)
   ) dut (
      .clk(clk), .reset(reset), .wr_addr_up(wr_addr_up), .rd_addr_up(rd_addr_up),
      .clr_err(clr_err), .wr_addr(wr_addr), .rd_addr(rd_addr), .write_en(write_en),
      .read_en(read_en), .filled_blks(filled_blks), .overflow(overflow), .underflow(underflow)
`ifdef DDR_ADDR_LEVEL_EN
      , .fill_words(fill_words), .almost_full(almost_full)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       name;
      logic [31:0] wa, ra;
      logic        we, re;
      logic [1:0]  fb;
      logic        ov, un;
      logic [31:0] fw;
      logic        af;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
      end
   endtask

   // Monitor: compare every expectation due in the current cycle, away from the active edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp(e.name, "wr_addr", 32'(wr_addr), e.wa);
         cmp(e.name, "rd_addr", 32'(rd_addr), e.ra);
         cmp(e.name, "write_en", 32'(write_en), 32'(e.we));
         cmp(e.name, "read_en", 32'(read_en), 32'(e.re));
         cmp(e.name, "filled_blks", 32'(filled_blks), 32'(e.fb));
         cmp(e.name, "overflow", 32'(overflow), 32'(e.ov));
         cmp(e.name, "underflow", 32'(underflow), 32'(e.un));
`ifdef DDR_ADDR_LEVEL_EN
         cmp(e.name, "fill_words", 32'(fill_words), e.fw);
         cmp(e.name, "almost_full", 32'(almost_full), 32'(e.af));
`endif
      end
   end

   task automatic step(input logic r, input logic w, input logic rd, input logic c);
      reset = r; wr_addr_up = w; rd_addr_up = rd; clr_err = c;
      @(posedge clk); #1;
      reset = 1'b0; wr_addr_up = 1'b0; rd_addr_up = 1'b0; clr_err = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] wa, input logic [31:0] ra,
                      input logic we, input logic re, input logic [1:0] fb,
                      input logic ov, input logic un, input logic [31:0] fw, input logic af);
      exp_t e;
      e.cyc = cyc; e.name = name; e.wa = wa; e.ra = ra; e.we = we; e.re = re;
      e.fb = fb; e.ov = ov; e.un = un; e.fw = fw; e.af = af;
      exp_q.push_back(e);
   endtask

   initial begin
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("reset", 'h100, 'h100, 1, 0, 0, 0, 0, 0, 0);

      // Fill block 0
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      chk("wr3", 'h106, 'h100, 1, 0, 0, 0, 0, 6, 0);
      step(0, 1, 0, 0);
      chk("wr4_blk_done", 'h108, 'h100, 1, 1, 1, 0, 0, 8, 0);

      // Fill block 1 and wrap; ring then full
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      chk("wr8_full", 'h100, 'h100, 0, 1, 2, 0, 0, 16, 1);
      step(0, 1, 0, 0);
      chk("wr9_overflow", 'h100, 'h100, 0, 1, 2, 1, 0, 16, 1);
      step(0, 0, 0, 1);
      chk("clr_overflow", 'h100, 'h100, 0, 1, 2, 0, 0, 16, 1);

      // Consume block 0, then position both sides at the last burst of a block
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      chk("rd4_consumed", 'h100, 'h108, 1, 1, 1, 0, 0, 8, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      chk("off6_both", 'h106, 'h10E, 1, 1, 1, 0, 0, 8, 0);
      step(0, 1, 1, 0);
      chk("simul_done", 'h108, 'h100, 1, 1, 1, 0, 0, 8, 0);

      // Drain block 0, then underflow
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      chk("empty", 'h108, 'h108, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("underflow", 'h108, 'h108, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 1);
      chk("clr_and_err", 'h108, 'h108, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("clr_underflow", 'h108, 'h108, 1, 0, 0, 0, 0, 0, 0);

      // Reset mid-operation after 5 writes and 2 reads
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("pre_reset", 'h10A, 'h104, 1, 1, 1, 0, 0, 6, 0);
      step(1, 1, 1, 0);
      chk("mid_reset", 'h100, 'h100, 1, 0, 0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
